// File: rtl/rsa_exp_arbiter.sv
// Shares one modular-exponentiation engine between two RSA requesters.
// It arbitrates round-robin, sequences the engine handshake and aborts hung operations.
module rsa_exp_arbiter #(
    parameter int WIDTH   = 256,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_ready,
    input  logic [WIDTH-1:0] req0_e,
    input  logic [WIDTH-1:0] req0_n,
    input  logic [WIDTH-1:0] req0_m,
    output logic             req0_ack,
    output logic             req0_valid,
    output logic [WIDTH-1:0] req0_c,
    output logic             req0_err,
    input  logic             req1_ready,
    input  logic [WIDTH-1:0] req1_e,
    input  logic [WIDTH-1:0] req1_n,
    input  logic [WIDTH-1:0] req1_m,
    output logic             req1_ack,
    output logic             req1_valid,
    output logic [WIDTH-1:0] req1_c,
    output logic             req1_err,
    output logic             me_start,
    output logic [WIDTH-1:0] me_base,
    output logic [WIDTH-1:0] me_exp,
    output logic [WIDTH-1:0] me_mod,
    output logic             me_abort,
    input  logic             me_valid,
    input  logic [WIDTH-1:0] me_result,
    output logic [2:0]       dbg_state
);
    // Handshake: reqN_ready is a level held until reqN_ack; every output is a
    // one-cycle pulse decoded from the registered state, never from an input.

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              from_wait_q, from_wait_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [WIDTH-1:0]  e_q, e_d, n_q, n_d, m_q, m_d;
    logic [WIDTH-1:0]  c0_q, c0_d, c1_q, c1_d;
    logic              grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            from_wait_q  <= 1'b0;
            wd_q         <= '0;
            e_q          <= '0;
            n_q          <= '0;
            m_q          <= '0;
            c0_q         <= '0;
            c1_q         <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            from_wait_q  <= from_wait_d;
            wd_q         <= wd_d;
            e_q          <= e_d;
            n_q          <= n_d;
            m_q          <= m_d;
            c0_q         <= c0_d;
            c1_q         <= c1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        from_wait_d  = from_wait_q;
        wd_d         = wd_q;
        e_d          = e_q;
        n_d          = n_q;
        m_d          = m_q;
        c0_d         = c0_q;
        c1_d         = c1_q;
        // On a tie the port that was not served last wins.
        grant        = (req0_ready && req1_ready) ? ~last_grant_q : req1_ready;
        case (state_q)
            S_IDLE: begin
                if (req0_ready || req1_ready) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    from_wait_d  = 1'b0;
                    e_d          = grant ? req1_e : req0_e;
                    n_d          = grant ? req1_n : req0_n;
                    m_d          = grant ? req1_m : req0_m;
                    state_d      = ((grant ? req1_n : req0_n) == '0) ? S_ERR : S_START;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the timeout edge still counts as success.
                if (me_valid) begin
                    if (owner_q) c1_d = me_result;
                    else         c0_d = me_result;
                    state_d = S_DONE;
                end else if (wd_q == WD_LAST) begin
                    from_wait_d = 1'b1;
                    state_d     = S_ERR;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Zero-modulus rejections acknowledge the request in the ERR cycle instead.
    logic ack_cycle;
    assign ack_cycle  = (state_q == S_START) || (state_q == S_ERR && !from_wait_q);

    assign req0_ack   = ack_cycle && !owner_q;
    assign req1_ack   = ack_cycle &&  owner_q;
    assign req0_valid = (state_q == S_DONE) && !owner_q;
    assign req1_valid = (state_q == S_DONE) &&  owner_q;
    assign req0_err   = (state_q == S_ERR) && !owner_q;
    assign req1_err   = (state_q == S_ERR) &&  owner_q;
    assign req0_c     = c0_q;
    assign req1_c     = c1_q;
    assign me_start   = (state_q == S_START);
    assign me_abort   = (state_q == S_ERR) && from_wait_q;
    assign me_base    = m_q;
    assign me_exp     = e_q;
    assign me_mod     = n_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_rsa_exp_arbiter.sv
// Directed bench for rsa_exp_arbiter: one task per scenario with inline comparisons.
module tb_rsa_exp_arbiter;
    localparam int W = 32;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_e, req0_n, req0_m, req1_e, req1_n, req1_m;
    logic         req0_ack, req0_valid, req0_err, req1_ack, req1_valid, req1_err;
    logic [W-1:0] req0_c, req1_c;
    logic         me_start, me_abort, me_valid;
    logic [W-1:0] me_base, me_exp, me_mod, me_result;
    logic [2:0]   dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    rsa_exp_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_ready(req0_ready), .req0_e(req0_e), .req0_n(req0_n), .req0_m(req0_m),
        .req0_ack(req0_ack), .req0_valid(req0_valid), .req0_c(req0_c), .req0_err(req0_err),
        .req1_ready(req1_ready), .req1_e(req1_e), .req1_n(req1_n), .req1_m(req1_m),
        .req1_ack(req1_ack), .req1_valid(req1_valid), .req1_c(req1_c), .req1_err(req1_err),
        .me_start(me_start), .me_base(me_base), .me_exp(me_exp), .me_mod(me_mod),
        .me_abort(me_abort), .me_valid(me_valid), .me_result(me_result),
        .dbg_state(dbg_state)
    );

    // Advance one edge; outputs are then observed and inputs driven 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_ready = 1'b0; req1_ready = 1'b0; me_valid = 1'b0; me_result = '0;
        req0_e = '0; req0_n = '0; req0_m = '0; req1_e = '0; req1_n = '0; req1_m = '0;
        tick(); tick();
        vec_cnt++; if ({req0_ack, req0_valid, req0_err, req1_ack, req1_valid, req1_err} !== 6'b0) begin
            err_cnt++; $display("FAIL reset_pulses got %b want 000000", {req0_ack, req0_valid, req0_err, req1_ack, req1_valid, req1_err}); end
        vec_cnt++; if ({me_start, me_abort} !== 2'b0) begin
            err_cnt++; $display("FAIL reset_me got %b want 00", {me_start, me_abort}); end
        vec_cnt++; if (req0_c !== 0 || req1_c !== 0) begin
            err_cnt++; $display("FAIL reset_c got %0d/%0d want 0/0", req0_c, req1_c); end
        vec_cnt++; if (me_mod !== 0 || me_base !== 0 || me_exp !== 0) begin
            err_cnt++; $display("FAIL reset_operands got %0d/%0d/%0d want 0", me_mod, me_base, me_exp); end
        reset = 1'b0;
        tick();
        vec_cnt++; if (dbg_state !== 3'd0) begin
            err_cnt++; $display("FAIL reset_idle got %0d want 0", dbg_state); end
    endtask

    task automatic test_single();
        req0_ready = 1'b1; req0_e = 3; req0_n = 33; req0_m = 4;
        tick();  // cycle T+1
        vec_cnt++; if (req0_ack !== 1'b1 || me_start !== 1'b1) begin
            err_cnt++; $display("FAIL single_ack got ack=%b start=%b want 1 1", req0_ack, me_start); end
        vec_cnt++; if (me_mod !== 33 || me_exp !== 3 || me_base !== 4) begin
            err_cnt++; $display("FAIL single_operands got n=%0d e=%0d m=%0d want 33 3 4", me_mod, me_exp, me_base); end
        vec_cnt++; if (req1_ack !== 1'b0) begin
            err_cnt++; $display("FAIL single_ack1 got %b want 0", req1_ack); end
        req0_ready = 1'b0;
        for (int i = 2; i <= 6; i++) begin
            tick();
            vec_cnt++; if (req0_valid !== 1'b0 || me_start !== 1'b0) begin
                err_cnt++; $display("FAIL single_early cycle T+%0d valid=%b start=%b want 0 0", i, req0_valid, me_start); end
            if (i == 6) begin me_valid = 1'b1; me_result = 31; end
        end
        tick();  // cycle T+7
        me_valid = 1'b0;
        vec_cnt++; if (req0_valid !== 1'b1 || req0_c !== 31) begin
            err_cnt++; $display("FAIL single_result got valid=%b c0=%0d want 1 31", req0_valid, req0_c); end
        vec_cnt++; if (req1_valid !== 1'b0 || req1_c !== 0 || req1_err !== 1'b0) begin
            err_cnt++; $display("FAIL single_port1 got valid=%b c1=%0d err=%b want 0 0 0", req1_valid, req1_c, req1_err); end
        tick();
        vec_cnt++; if (req0_valid !== 1'b0 || req0_c !== 31 || dbg_state !== 3'd0) begin
            err_cnt++; $display("FAIL single_after got valid=%b c0=%0d st=%0d want 0 31 0", req0_valid, req0_c, dbg_state); end
    endtask

    task automatic test_back_to_back();
        logic exp_port;
        reset = 1'b1;
        req0_ready = 1'b1; req0_e = 5; req0_n = 91; req0_m = 7;
        req1_ready = 1'b1; req1_e = 9; req1_n = 143; req1_m = 2;
        tick();
        reset = 1'b0;
        tick();  // START for first grant
        for (int k = 0; k < 4; k++) begin
            exp_port = k[0];
            vec_cnt++; if (req0_ack !== !exp_port || req1_ack !== exp_port || me_start !== 1'b1) begin
                err_cnt++; $display("FAIL b2b_grant op%0d got ack0=%b ack1=%b start=%b want port %0d", k, req0_ack, req1_ack, me_start, exp_port); end
            vec_cnt++; if (me_mod !== (exp_port ? 143 : 91)) begin
                err_cnt++; $display("FAIL b2b_mod op%0d got %0d want %0d", k, me_mod, exp_port ? 143 : 91); end
            tick();  // WAIT
            me_valid = 1'b1; me_result = 200 + k;
            tick();  // DONE
            me_valid = 1'b0;
            if (exp_port) begin
                vec_cnt++; if (req1_valid !== 1'b1 || req1_c !== 200 + k || req0_valid !== 1'b0) begin
                    err_cnt++; $display("FAIL b2b_result op%0d got v1=%b c1=%0d v0=%b want 1 %0d 0", k, req1_valid, req1_c, req0_valid, 200 + k); end
            end else begin
                vec_cnt++; if (req0_valid !== 1'b1 || req0_c !== 200 + k || req1_valid !== 1'b0) begin
                    err_cnt++; $display("FAIL b2b_result op%0d got v0=%b c0=%0d v1=%b want 1 %0d 0", k, req0_valid, req0_c, req1_valid, 200 + k); end
            end
            if (k == 3) begin req0_ready = 1'b0; req1_ready = 1'b0; end
            tick();  // IDLE
            tick();  // START of next op
        end
        vec_cnt++; if (dbg_state !== 3'd0 || req0_c !== 202 || req1_c !== 203) begin
            err_cnt++; $display("FAIL b2b_end got st=%0d c0=%0d c1=%0d want 0 202 203", dbg_state, req0_c, req1_c); end
    endtask

    task automatic test_zero_mod();
        req1_ready = 1'b1; req1_e = 3; req1_n = 0; req1_m = 8;
        tick();
        vec_cnt++; if (req1_ack !== 1'b1 || req1_err !== 1'b1) begin
            err_cnt++; $display("FAIL zmod_ack_err got ack1=%b err1=%b want 1 1", req1_ack, req1_err); end
        vec_cnt++; if (me_start !== 1'b0 || me_abort !== 1'b0 || req0_ack !== 1'b0 || req0_err !== 1'b0) begin
            err_cnt++; $display("FAIL zmod_side got start=%b abort=%b ack0=%b err0=%b want 0", me_start, me_abort, req0_ack, req0_err); end
        req1_ready = 1'b0;
        tick();
        vec_cnt++; if (req1_err !== 1'b0 || me_start !== 1'b0 || req1_c !== 203) begin
            err_cnt++; $display("FAIL zmod_after got err1=%b start=%b c1=%0d want 0 0 203", req1_err, me_start, req1_c); end
        req0_ready = 1'b1; req0_e = 7; req0_n = 55; req0_m = 2;
        tick();
        vec_cnt++; if (req0_ack !== 1'b1 || me_start !== 1'b1 || me_mod !== 55) begin
            err_cnt++; $display("FAIL zmod_next got ack0=%b start=%b n=%0d want 1 1 55", req0_ack, me_start, me_mod); end
        req0_ready = 1'b0;
        tick();
        me_valid = 1'b1; me_result = 9;
        tick();
        me_valid = 1'b0;
        vec_cnt++; if (req0_valid !== 1'b1 || req0_c !== 9) begin
            err_cnt++; $display("FAIL zmod_next_result got v0=%b c0=%0d want 1 9", req0_valid, req0_c); end
        tick();
    endtask

    task automatic test_timeout();
        req0_ready = 1'b1; req0_n = 77;
        tick();
        vec_cnt++; if (req0_ack !== 1'b1) begin
            err_cnt++; $display("FAIL to_ack got %b want 1", req0_ack); end
        req0_ready = 1'b0;
        for (int i = 0; i < TO; i++) begin
            tick();
            vec_cnt++; if (req0_err !== 1'b0 || me_abort !== 1'b0) begin
                err_cnt++; $display("FAIL to_early wait%0d err0=%b abort=%b want 0 0", i, req0_err, me_abort); end
        end
        tick();
        vec_cnt++; if (req0_err !== 1'b1 || me_abort !== 1'b1) begin
            err_cnt++; $display("FAIL to_abort got err0=%b abort=%b want 1 1", req0_err, me_abort); end
        vec_cnt++; if (req0_ack !== 1'b0 || req0_valid !== 1'b0 || req1_err !== 1'b0) begin
            err_cnt++; $display("FAIL to_side got ack0=%b v0=%b err1=%b want 0 0 0", req0_ack, req0_valid, req1_err); end
        tick();
        me_valid = 1'b1; me_result = 32'hdead;
        tick();
        me_valid = 1'b0;
        vec_cnt++; if (req0_valid !== 1'b0 || req0_c !== 9 || dbg_state !== 3'd0) begin
            err_cnt++; $display("FAIL to_late got v0=%b c0=%0d st=%0d want 0 9 0", req0_valid, req0_c, dbg_state); end
    endtask

    task automatic test_valid_on_timeout();
        req0_ready = 1'b1; req0_n = 77;
        tick();
        req0_ready = 1'b0;
        for (int i = 0; i < TO; i++) begin
            tick();
            if (i == TO - 1) begin me_valid = 1'b1; me_result = 77; end
        end
        tick();
        me_valid = 1'b0;
        vec_cnt++; if (req0_valid !== 1'b1 || req0_c !== 77) begin
            err_cnt++; $display("FAIL vto_result got v0=%b c0=%0d want 1 77", req0_valid, req0_c); end
        vec_cnt++; if (req0_err !== 1'b0 || me_abort !== 1'b0) begin
            err_cnt++; $display("FAIL vto_noerr got err0=%b abort=%b want 0 0", req0_err, me_abort); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        req0_ready = 1'b1; req0_e = 1; req0_n = 5; req0_m = 3;
        tick();
        req0_ready = 1'b0;
        tick(); tick();
        vec_cnt++; if (dbg_state !== 3'd2) begin
            err_cnt++; $display("FAIL rmid_inwait got st=%0d want 2", dbg_state); end
        reset = 1'b1;
        tick();
        vec_cnt++; if ({req0_ack, req0_valid, req0_err, req1_ack, req1_valid, req1_err, me_start, me_abort} !== 8'b0) begin
            err_cnt++; $display("FAIL rmid_pulses got %b want 00000000", {req0_ack, req0_valid, req0_err, req1_ack, req1_valid, req1_err, me_start, me_abort}); end
        vec_cnt++; if (req0_c !== 0 || req1_c !== 0 || me_mod !== 0 || dbg_state !== 3'd0) begin
            err_cnt++; $display("FAIL rmid_cleared got c0=%0d c1=%0d n=%0d st=%0d want 0 0 0 0", req0_c, req1_c, me_mod, dbg_state); end
        req0_ready = 1'b1; req1_ready = 1'b1; req1_n = 13;
        tick();
        reset = 1'b0;
        tick();
        vec_cnt++; if (req0_ack !== 1'b1 || req1_ack !== 1'b0 || me_mod !== 5) begin
            err_cnt++; $display("FAIL rmid_tie got ack0=%b ack1=%b n=%0d want 1 0 5", req0_ack, req1_ack, me_mod); end
        req0_ready = 1'b0; req1_ready = 1'b0;
        tick();
        me_valid = 1'b1; me_result = 4;
        tick();
        me_valid = 1'b0;
        vec_cnt++; if (req0_valid !== 1'b1 || req0_c !== 4) begin
            err_cnt++; $display("FAIL rmid_result got v0=%b c0=%0d want 1 4", req0_valid, req0_c); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_mod();
        test_timeout();
        test_valid_on_timeout();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/rsa_exp_arbiter.md
# rsa_exp_arbiter

Controller that shares one modular-exponentiation engine between two RSA requesters (port 0: encrypt path, port 1: decrypt/sign path). It arbitrates round-robin, latches the winner's operands, sequences the engine's start/done handshake, and returns the result only to the owning requester. A watchdog aborts hung operations. It sits between the encrypt/decrypt wrappers and the single `mod_exp` instance.

## Interface
- WIDTH, 256, operand/result width in bits
- TIMEOUT, 4096, maximum WAIT cycles before abort (≥2)

- clk  in  1  rising-edge clock; one clock, single domain
- reset  in  1  synchronous, active-high; clears all state
- reqN_ready  in  1  (N=0,1) request level; requester holds until reqN_ack
- reqN_e, reqN_n, reqN_m  in  WIDTH  exponent, modulus, message; sampled only at grant
- reqN_ack  out  1  one-cycle pulse: request accepted, operands captured
- reqN_valid  out  1  one-cycle pulse: reqN_c holds a new result
- reqN_c  out  WIDTH  result; held until next completion for port N
- reqN_err  out  1  one-cycle pulse: request failed (zero modulus or timeout)
- me_start  out  1  one-cycle engine start pulse
- me_base, me_exp, me_mod  out  WIDTH  latched operands, stable from START until return to IDLE
- me_abort  out  1  one-cycle pulse on timeout; engine must return to idle
- me_valid  in  1  engine done strobe
- me_result  in  WIDTH  engine result, valid with me_valid

## Operation
- States: IDLE, START, WAIT, DONE, ERR.
- IDLE: if any reqN_ready, grant. Only one pending → that port. Both pending → port not served last (last_grant flag). After reset last_grant=1, so port 0 wins the first tie.
- Grant edge: latch owner, e/n/m into operand registers, update last_grant. If latched n==0 → ERR (engine never started); else → START.
- START: me_start=1, reqOwner_ack=1; clear watchdog; → WAIT.
- WAIT: watchdog increments each cycle. me_valid=1 → capture me_result into reqOwner_c, → DONE. Watchdog reaches TIMEOUT-1 with me_valid=0 → ERR. Both on same edge: me_valid wins.
- DONE: reqOwner_valid=1; → IDLE.
- ERR: reqOwner_err=1; me_abort=1 only if entered from WAIT; reqOwner_ack=1 also if entered from grant (zero modulus); → IDLE.
- me_valid outside WAIT is ignored; results never reach a non-owner port.
- Non-owner reqN_c untouched by an operation.
- reqN_ready still high in IDLE after completion → treated as a new request.

## Timing
- Reset values: all ack/valid/err/me_start/me_abort = 0; reqN_c = 0; operand registers = 0; state IDLE; watchdog 0; last_grant = 1.
- Reset mid-operation: next cycle IDLE, no pulses, no me_abort issued; engine receives reset directly.
- Request sampled at edge T → ack and me_start during cycle T+1 (same cycle).
- Engine latency L ≥ 1: me_valid in cycle T+1+L → reqN_valid during cycle T+2+L. Throughput: one op per L+3 cycles; back-to-back grants possible from IDLE cycle after DONE.
- Zero modulus: edge T → ack and err both during T+1; no me_start.
- Timeout: err and me_abort during the cycle after TIMEOUT WAIT cycles elapse.
- All outputs registered/state-decoded; no combinational path from reqN_ready or me_valid to outputs.

## Test plan
- Single req0: e=3, n=33, m=4; engine model L=5 returns 31 → ack0 at T+1, valid0 at T+7 with c0=31; port 1 outputs stay 0.
- Simultaneous req0 and req1 held from reset → port 0 served first, then port 1; with both re-requesting continuously, grants alternate 0,1,0,1.
- req1 with n=0 → ack1 and err1 same cycle, me_start never asserts, next request served normally.
- Engine never responds, TIMEOUT=16 → err0 and me_abort pulse 16 cycles after entering WAIT; late me_valid afterwards ignored, c0 unchanged.
- Reset asserted during WAIT → all outputs 0 next cycle, c0/c1 cleared, following req0 wins tie.
- me_valid on exactly the timeout edge → valid0 with result, no err0, no me_abort.
